// File: rtl/ifetch_queue_if.sv
// Handshake bundle between the fetch queue, instruction memory and the IF/ID stage.
// The master modport is the queue side; the slave modport is the memory/decode side.
interface ifetch_queue_if;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        out_valid;
  logic [31:0] out_pc_four;
  logic [31:0] out_instr;
  logic        out_ready;

  modport master (
    input  redirect_valid, redirect_pc, mem_ack, mem_rdata, out_ready,
    output mem_req, mem_addr, out_valid, out_pc_four, out_instr
  );

  modport slave (
    output redirect_valid, redirect_pc, mem_ack, mem_rdata, out_ready,
    input  mem_req, mem_addr, out_valid, out_pc_four, out_instr
  );
endinterface

// File: rtl/ifetch_queue.sv
// Instruction prefetch queue: one outstanding memory request, a DEPTH-entry FIFO of
// {pc+4, instr}, and flush/refetch on redirect with an abandoned request drained in DROP.
module ifetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic           clk,
  input  logic           rst,
  ifetch_queue_if.master bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

  state_t             state_q, state_d;
  logic [31:0]        fetch_pc_q, fetch_pc_d;
  logic [31:0]        drop_addr_q, drop_addr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [CNT_W-1:0]   post_cnt;
  logic [31:0]        pc_four_mem [DEPTH];
  logic [31:0]        instr_mem   [DEPTH];
  logic               valid, push, pop;

  assign valid = (count_q != '0);

  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    drop_addr_d = drop_addr_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    push        = 1'b0;
    pop         = valid && bus.out_ready && !bus.redirect_valid;
    post_cnt    = count_q + CNT_W'(1) - CNT_W'(pop);

    unique case (state_q)
      IDLE: begin
        if (!bus.redirect_valid && (count_q < FULL)) state_d = WAIT;
      end
      WAIT: begin
        if (bus.redirect_valid) begin
          // The in-flight word belongs to the old path; drain it if it has not come back yet.
          state_d     = bus.mem_ack ? IDLE : DROP;
          drop_addr_d = fetch_pc_q;
        end else if (bus.mem_ack) begin
          push       = 1'b1;
          fetch_pc_d = fetch_pc_q + 32'd4;
          state_d    = (post_cnt < FULL) ? WAIT : IDLE;
        end
      end
      DROP: begin
        if (bus.mem_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (bus.redirect_valid) begin
      fetch_pc_d = bus.redirect_pc;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      fetch_pc_q  <= RESET_PC;
      drop_addr_q <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      drop_addr_q <= drop_addr_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !rst) begin
      pc_four_mem[wr_ptr_q] <= fetch_pc_q + 32'd4;
      instr_mem[wr_ptr_q]   <= bus.mem_rdata;
    end
  end

  assign bus.mem_req     = (state_q != IDLE);
  assign bus.mem_addr    = (state_q == WAIT) ? fetch_pc_q :
                           (state_q == DROP) ? drop_addr_q : 32'd0;
  assign bus.out_valid   = valid;
  assign bus.out_pc_four = valid ? pc_four_mem[rd_ptr_q] : 32'd0;
  assign bus.out_instr   = valid ? instr_mem[rd_ptr_q]   : 32'd0;
endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue: streaming, full queue, redirects, address wrap and reset.
module tb_ifetch_queue;
  logic clk;
  logic rst;
  logic auto_ack;
  logic man_ack;
  int   checks;
  int   fails;

  ifetch_queue_if bus ();

  ifetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_3000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [31:0] memf(input logic [31:0] a);
    return a ^ 32'h5A5A_A5A5;
  endfunction

  // Memory model: either zero-latency (ack whenever requested) or manually acked.
  assign bus.mem_ack   = auto_ack ? bus.mem_req : man_ack;
  assign bus.mem_rdata = memf(bus.mem_addr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic rdy, input logic aack);
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'd0;
    bus.out_ready      = rdy;
    man_ack  = 1'b0;
    auto_ack = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    auto_ack = aack;
  endtask

  task automatic test_reset();
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'd0;
    bus.out_ready      = 1'b1;
    auto_ack = 1'b0;
    man_ack  = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    checks++; if (bus.mem_req !== 1'b0) begin fails++; $display("FAIL rst_mem_req got=%h exp=0", bus.mem_req); end
    checks++; if (bus.mem_addr !== 32'd0) begin fails++; $display("FAIL rst_mem_addr got=%h exp=0", bus.mem_addr); end
    checks++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL rst_out_valid got=%h exp=0", bus.out_valid); end
    checks++; if (bus.out_pc_four !== 32'd0) begin fails++; $display("FAIL rst_pc_four got=%h exp=0", bus.out_pc_four); end
    checks++; if (bus.out_instr !== 32'd0) begin fails++; $display("FAIL rst_instr got=%h exp=0", bus.out_instr); end
    rst = 1'b0;
    tick();
    checks++; if (bus.mem_req !== 1'b1) begin fails++; $display("FAIL first_req got=%h exp=1", bus.mem_req); end
    checks++; if (bus.mem_addr !== 32'h0000_3000) begin fails++; $display("FAIL first_addr got=%h exp=00003000", bus.mem_addr); end
  endtask

  task automatic test_stream();
    logic [31:0] pcs [3];
    logic [31:0] ins [3];
    pcs = '{32'h0000_3004, 32'h0000_3008, 32'h0000_300C};
    ins = '{32'h5A5A_95A5, 32'h5A5A_95A1, 32'h5A5A_95AD};
    do_reset(1'b1, 1'b1);
    tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (bus.out_valid !== 1'b1) begin fails++; $display("FAIL stream_valid[%0d] got=%h exp=1", i, bus.out_valid); end
      checks++; if (bus.out_pc_four !== pcs[i]) begin fails++; $display("FAIL stream_pc[%0d] got=%h exp=%h", i, bus.out_pc_four, pcs[i]); end
      checks++; if (bus.out_instr !== ins[i]) begin fails++; $display("FAIL stream_instr[%0d] got=%h exp=%h", i, bus.out_instr, ins[i]); end
    end
  endtask

  task automatic test_full();
    logic [31:0] heads [4];
    logic        reqs  [4];
    heads = '{32'h0000_3008, 32'h0000_300C, 32'h0000_3010, 32'h0000_3014};
    reqs  = '{1'b0, 1'b1, 1'b1, 1'b1};
    do_reset(1'b0, 1'b1);
    repeat (4) tick();
    checks++; if (bus.mem_req !== 1'b1) begin fails++; $display("FAIL full_fetching got=%h exp=1", bus.mem_req); end
    tick();
    checks++; if (bus.mem_req !== 1'b0) begin fails++; $display("FAIL full_stop got=%h exp=0", bus.mem_req); end
    repeat (2) tick();
    checks++; if (bus.mem_req !== 1'b0) begin fails++; $display("FAIL full_hold got=%h exp=0", bus.mem_req); end
    checks++; if (bus.out_pc_four !== 32'h0000_3004) begin fails++; $display("FAIL full_head got=%h exp=00003004", bus.out_pc_four); end
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (bus.out_pc_four !== heads[i]) begin fails++; $display("FAIL drain_pc[%0d] got=%h exp=%h", i, bus.out_pc_four, heads[i]); end
      checks++; if (bus.mem_req !== reqs[i]) begin fails++; $display("FAIL drain_req[%0d] got=%h exp=%h", i, bus.mem_req, reqs[i]); end
      if (i == 1) begin
        checks++; if (bus.mem_addr !== 32'h0000_3010) begin fails++; $display("FAIL resume_addr got=%h exp=00003010", bus.mem_addr); end
      end
      if (i == 2) begin
        checks++; if (bus.out_instr !== 32'h5A5A_95A9) begin fails++; $display("FAIL drain_instr got=%h exp=5a5a95a9", bus.out_instr); end
      end
    end
  endtask

  task automatic test_redirect_drop();
    do_reset(1'b1, 1'b0);
    tick();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_3100;
    tick();
    bus.redirect_valid = 1'b0;
    checks++; if (bus.mem_req !== 1'b1) begin fails++; $display("FAIL drop_req got=%h exp=1", bus.mem_req); end
    checks++; if (bus.mem_addr !== 32'h0000_3000) begin fails++; $display("FAIL drop_addr got=%h exp=00003000", bus.mem_addr); end
    tick();
    checks++; if (bus.mem_addr !== 32'h0000_3000) begin fails++; $display("FAIL drop_hold got=%h exp=00003000", bus.mem_addr); end
    man_ack = 1'b1;
    tick();
    man_ack = 1'b0;
    checks++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL drop_discard got=%h exp=0", bus.out_valid); end
    checks++; if (bus.mem_req !== 1'b0) begin fails++; $display("FAIL drop_idle got=%h exp=0", bus.mem_req); end
    tick();
    checks++; if (bus.mem_addr !== 32'h0000_3100) begin fails++; $display("FAIL drop_new_addr got=%h exp=00003100", bus.mem_addr); end
    man_ack = 1'b1;
    tick();
    man_ack = 1'b0;
    checks++; if (bus.out_pc_four !== 32'h0000_3104) begin fails++; $display("FAIL drop_new_pc got=%h exp=00003104", bus.out_pc_four); end
    checks++; if (bus.out_instr !== 32'h5A5A_94A5) begin fails++; $display("FAIL drop_new_instr got=%h exp=5a5a94a5", bus.out_instr); end
  endtask

  task automatic test_redirect_ack_pop();
    do_reset(1'b0, 1'b1);
    repeat (3) tick();
    checks++; if (bus.mem_addr !== 32'h0000_3008) begin fails++; $display("FAIL rap_pre_addr got=%h exp=00003008", bus.mem_addr); end
    bus.out_ready      = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_4000;
    tick();
    bus.redirect_valid = 1'b0;
    auto_ack = 1'b0;
    checks++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL rap_valid got=%h exp=0", bus.out_valid); end
    checks++; if (bus.out_pc_four !== 32'd0) begin fails++; $display("FAIL rap_pc got=%h exp=0", bus.out_pc_four); end
    checks++; if (bus.mem_req !== 1'b0) begin fails++; $display("FAIL rap_req got=%h exp=0", bus.mem_req); end
    tick();
    checks++; if (bus.mem_addr !== 32'h0000_4000) begin fails++; $display("FAIL rap_addr got=%h exp=00004000", bus.mem_addr); end
    man_ack = 1'b1;
    tick();
    man_ack = 1'b0;
    checks++; if (bus.out_pc_four !== 32'h0000_4004) begin fails++; $display("FAIL rap_new_pc got=%h exp=00004004", bus.out_pc_four); end
    checks++; if (bus.out_instr !== 32'h5A5A_E5A5) begin fails++; $display("FAIL rap_new_instr got=%h exp=5a5ae5a5", bus.out_instr); end
  endtask

  task automatic test_wrap();
    logic [31:0] pcs [10];
    pcs = '{32'hFFFF_FFF4, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004,
            32'h0000_0008, 32'h0000_000C, 32'h0000_0010, 32'h0000_0014, 32'h0000_0018};
    do_reset(1'b1, 1'b0);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'hFFFF_FFF0;
    tick();
    bus.redirect_valid = 1'b0;
    checks++; if (bus.mem_req !== 1'b0) begin fails++; $display("FAIL wrap_idle got=%h exp=0", bus.mem_req); end
    auto_ack = 1'b1;
    tick();
    checks++; if (bus.mem_addr !== 32'hFFFF_FFF0) begin fails++; $display("FAIL wrap_start got=%h exp=fffffff0", bus.mem_addr); end
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++; if (bus.out_pc_four !== pcs[i]) begin fails++; $display("FAIL wrap_pc[%0d] got=%h exp=%h", i, bus.out_pc_four, pcs[i]); end
      checks++; if (bus.out_instr !== memf(pcs[i] - 32'd4)) begin fails++; $display("FAIL wrap_instr[%0d] got=%h exp=%h", i, bus.out_instr, memf(pcs[i] - 32'd4)); end
      checks++; if (bus.mem_addr !== pcs[i]) begin fails++; $display("FAIL wrap_addr[%0d] got=%h exp=%h", i, bus.mem_addr, pcs[i]); end
    end
    auto_ack = 1'b0;
  endtask

  task automatic test_rst_in_wait();
    do_reset(1'b0, 1'b0);
    tick();
    man_ack = 1'b1;
    tick();
    man_ack = 1'b0;
    checks++; if (bus.out_valid !== 1'b1) begin fails++; $display("FAIL rw_pre_valid got=%h exp=1", bus.out_valid); end
    rst = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_5000;
    tick();
    checks++; if (bus.mem_req !== 1'b0) begin fails++; $display("FAIL rw_req got=%h exp=0", bus.mem_req); end
    checks++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL rw_valid got=%h exp=0", bus.out_valid); end
    checks++; if (bus.mem_addr !== 32'd0) begin fails++; $display("FAIL rw_addr got=%h exp=0", bus.mem_addr); end
    rst = 1'b0;
    bus.redirect_valid = 1'b0;
    man_ack = 1'b1;
    tick();
    man_ack = 1'b0;
    checks++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL rw_late_ack got=%h exp=0", bus.out_valid); end
    checks++; if (bus.mem_req !== 1'b1) begin fails++; $display("FAIL rw_first_req got=%h exp=1", bus.mem_req); end
    checks++; if (bus.mem_addr !== 32'h0000_3000) begin fails++; $display("FAIL rw_first_addr got=%h exp=00003000", bus.mem_addr); end
  endtask

  initial begin
    checks   = 0;
    fails    = 0;
    rst      = 1'b1;
    auto_ack = 1'b0;
    man_ack  = 1'b0;
    test_reset();
    test_stream();
    test_full();
    test_redirect_drop();
    test_redirect_ack_pop();
    test_wrap();
    test_rst_in_wait();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/ifetch_queue.md
IFETCH_QUEUE -- requirements
Module: ifetch_queue

Interface
REQ-001 Parameter DEPTH, 4, number of prefetch entries; a power of two, at least 2.
REQ-002 Parameter RESET_PC, 32'h0000_3000, first fetch address after reset.
REQ-003 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port rst  input  1  reset, synchronous and active-high.
REQ-005 Port redirect_valid  input  1  branch/jump taken in decode; flush the queue and refetch.
REQ-006 Port redirect_pc  input  32  new fetch address, sampled when redirect_valid=1.
REQ-007 Port mem_req  output  1  instruction-memory request; held high until acknowledged.
REQ-008 Port mem_addr  output  32  word address of the request; stable while mem_req=1.
REQ-009 Port mem_ack  input  1  one-cycle acknowledge; mem_rdata is valid in the same cycle.
REQ-010 Port mem_rdata  input  32  instruction word returned by memory.
REQ-011 Port out_valid  output  1  head entry is valid for the IF/ID register.
REQ-012 Port out_pc_four  output  32  address of the head instruction plus 4.
REQ-013 Port out_instr  output  32  head instruction word.
REQ-014 Port out_ready  input  1  IF/ID write enable (ifwrite); low during a load-use stall.

Function
REQ-015 Internal state SHALL be: fetch_pc (32 bits), a circular FIFO of DEPTH {pc_four, instr} entries, rd_ptr/wr_ptr (log2 DEPTH bits, wrapping modulo DEPTH), count (0..DEPTH), and FSM states IDLE, WAIT and DROP.
REQ-016 mem_req SHALL be 1 in WAIT and DROP and 0 in IDLE; mem_addr SHALL equal fetch_pc in WAIT and the abandoned address in DROP.
REQ-017 IDLE->WAIT SHALL occur when count < DEPTH and redirect_valid=0; otherwise remain in IDLE.
REQ-018 WAIT with mem_ack=1 and no redirect SHALL push {fetch_pc+4, mem_rdata} at wr_ptr and set fetch_pc += 4 (32-bit wrap, FFFF_FFFC->0000_0000); the next state is WAIT if the post-cycle count < DEPTH, else IDLE.
REQ-019 WAIT with mem_ack=0 SHALL hold mem_addr and mem_req unchanged.
REQ-020 Pop SHALL occur when out_valid & out_ready: rd_ptr++ and count--; a simultaneous push and pop leaves count unchanged.
REQ-021 out_valid SHALL equal (count != 0); out_pc_four and out_instr SHALL show the entry at rd_ptr, and SHALL be 0 when count=0.
REQ-022 Latency: an instruction acknowledged in cycle N SHALL appear on the outputs in cycle N+1 if the queue was empty.
REQ-023 Redirect SHALL take priority over push and pop: count, rd_ptr and wr_ptr become 0 and fetch_pc becomes redirect_pc, and no pop occurs that cycle.
REQ-024 Redirect in WAIT with mem_ack=0 SHALL go to DROP, holding mem_req high at the old address until the ack arrives.
REQ-025 Redirect in WAIT with mem_ack=1 SHALL discard mem_rdata and go to IDLE.
REQ-026 DROP with mem_ack=1 SHALL discard the data and go to IDLE; a redirect during DROP SHALL update fetch_pc and stay in DROP.
REQ-027 At most one request SHALL be outstanding, and a push SHALL never occur while count=DEPTH.

Reset
REQ-028 rst=1 SHALL set state IDLE, fetch_pc=RESET_PC, count=0 and both pointers to 0, and drive mem_req=0, mem_addr=0, out_valid=0, out_pc_four=0 and out_instr=0 in the following cycle.
REQ-029 rst SHALL override redirect and any in-flight request; an ack that arrives after reset SHALL be ignored.
REQ-030 The first mem_req SHALL rise one cycle after rst falls, with mem_addr=RESET_PC.

Verification
REQ-031 Reset; zero-latency memory; out_ready=1 -> out_pc_four sequence 3004, 3008, 300C, with the instr words matching memory.
REQ-032 out_ready=0; continuous acks -> exactly 4 pushes, then mem_req=0 and count=4; raising out_ready pops 4 entries in order and fetching resumes.
REQ-033 Redirect to 0x3100 while WAIT, ack pending for 3 cycles -> DROP, the returned word is not queued, and the next request addr is 0x3100.
REQ-034 Redirect in the same cycle as ack plus pop with count=2 -> queue empty next cycle, data discarded, next request addr is redirect_pc.
REQ-035 fetch_pc=FFFF_FFFC acked -> entry pc_four=0000_0000 and next request addr 0000_0000; pointer wrap verified over 10 entries.
REQ-036 rst asserted in WAIT -> next cycle mem_req=0 and out_valid=0; a late ack is ignored, and the first request after reset is to RESET_PC.
